// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO multiply/divide unit for the E stage.
//   clk, reset (async, active-high), en (E-stage op valid), HLOp[3:0] (op code),
//   A/B (rs/rt operands) -> start (op accepted, comb), busy (registered),
//   HI/LO (architectural registers), MDOut (HI on mfhi, else LO).
// Divider is built only when the macro MDU_DIV_EN is defined; otherwise
// div/divu decode as none.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       HLOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MTHI  = 4'd8
  } hlop_e;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic             wr_p_q, wr_p_d;

  logic             is_mul, is_div;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  assign is_mul = (HLOp == OP_MULT) || (HLOp == OP_MULTU);
  // Operands widened by hand so the low 2*WIDTH bits hold the exact product.
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

`ifdef MDU_DIV_EN
  logic                    b_zero, s_ovf;
  logic signed [WIDTH-1:0] dvs_s, q_s, r_s;
  logic [WIDTH-1:0]        dvs_u, q_u, r_u;

  assign is_div = (HLOp == OP_DIV) || (HLOp == OP_DIVU);
  assign b_zero = (B == '0);
  assign s_ovf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  // Dividing by 1 in the zero/overflow cases keeps the divider well defined;
  // for MIN/-1 it also yields exactly LO=A, HI=0.
  assign dvs_s  = (b_zero || s_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
  assign dvs_u  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
  assign q_s    = $signed(A) / dvs_s;
  assign r_s    = $signed(A) % dvs_s;
  assign q_u    = A / dvs_u;
  assign r_u    = A % dvs_u;
`else
  assign is_div = 1'b0;
`endif

  assign busy  = (state_q == BUSY);
  assign start = en & ~busy & (is_mul | is_div) & ~reset;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = (HLOp == OP_MFHI) ? hi_q : lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    wr_p_d  = wr_p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CW'(MULT_CYCLES);
          wr_p_d  = 1'b1;
          case (HLOp)
            OP_MULT:  {hi_p_d, lo_p_d} = prod_s;
            OP_MULTU: {hi_p_d, lo_p_d} = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV: begin
              cnt_d  = CW'(DIV_CYCLES);
              wr_p_d = ~b_zero;
              hi_p_d = r_s;
              lo_p_d = q_s;
            end
            OP_DIVU: begin
              cnt_d  = CW'(DIV_CYCLES);
              wr_p_d = ~b_zero;
              hi_p_d = r_u;
              lo_p_d = q_u;
            end
`endif
            default: wr_p_d = 1'b0;
          endcase
        end else if (en) begin
          if (HLOp == OP_MTHI) hi_d = A;
          if (HLOp == OP_MTLO) lo_d = A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (wr_p_q) begin
            hi_d = hi_p_q;
            lo_d = lo_p_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_p_q  <= '0;
      lo_p_q  <= '0;
      wr_p_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      wr_p_q  <= wr_p_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [3:0]    HLOp;
  logic [W-1:0]  A, B;
  logic          start, busy;
  logic [W-1:0]  HI, LO, MDOut;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .en(en), .HLOp(HLOp), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        scb[$];
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    longint      sa, sbv, q, rm;
    logic [63:0] ua, ub, p;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    r.hi  = arch_hi;
    r.lo  = arch_lo;
    r.lat = MC;
    case (op)
      4'd1: begin p = sa * sbv; r.hi = p[63:32]; r.lo = p[31:0]; end
      4'd2: begin p = ua * ub;  r.hi = p[63:32]; r.lo = p[31:0]; end
      4'd3: begin
        r.lat = DC;
        if (b != 0) begin
          q = sa / sbv; rm = sa % sbv;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end
      end
      4'd4: begin
        r.lat = DC;
        if (b != 0) begin
          p = ua / ub; r.lo = p[31:0];
          p = ua % ub; r.hi = p[31:0];
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // One cycle of stimulus: drive at negedge, check, then apply at posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic e);
    bit idle, acc;
    @(negedge clk);
    en = e; HLOp = op; A = a; B = b;
    #1;
    idle = (scb.size() == 0);
    acc  = e && idle && (op == 4'd1 || op == 4'd2 || (DIV_EN && (op == 4'd3 || op == 4'd4)));
    chk("start", {31'b0, start}, {31'b0, acc});
    chk("busy", {31'b0, busy}, {31'b0, !idle});
    chk("HI", HI, arch_hi);
    chk("LO", LO, arch_lo);
    chk("MDOut", MDOut, (op == 4'd6) ? arch_hi : arch_lo);
    @(posedge clk);
    if (acc) scb.push_back(ref_op(op, a, b));
    else if (e && idle && op == 4'd8) arch_hi = a;
    else if (e && idle && op == 4'd7) arch_lo = a;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((scb.size() != 0 || busy) && n < 40) begin
      issue(4'd0, '0, '0, 1'b0);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT ends an operation.
  initial begin
    int   bcnt = 0;
    bit   prev = 1'b0;
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev = 1'b0;
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (prev && !busy) begin
          if (scb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit actual=commit expected=none");
          end else begin
            it = scb.pop_front();
            chk("latency", 32'(bcnt), 32'(it.lat));
            chk("commit_HI", HI, it.hi);
            chk("commit_LO", LO, it.lo);
            arch_hi = it.hi;
            arch_lo = it.lo;
          end
          bcnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; HLOp = 4'd0; A = '0; B = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_MDOut", MDOut, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // mult -3*7; second identical op while busy must not restart
    issue(4'd1, 32'hFFFFFFFD, 32'd7, 1'b1);
    issue(4'd1, 32'hFFFFFFFD, 32'd7, 1'b1);
    wait_idle();
    chk("d_mult_HI", HI, 32'hFFFFFFFF);
    chk("d_mult_LO", LO, 32'hFFFFFFEB);

    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_idle();
    chk("d_multu_HI", HI, 32'd1);
    chk("d_multu_LO", LO, 32'hFFFFFFFE);

`ifdef MDU_DIV_EN
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle();
    chk("d_div_LO", LO, 32'hFFFFFFFD);
    chk("d_div_HI", HI, 32'hFFFFFFFF);
    issue(4'd3, 32'd5, 32'd0, 1'b1);
    wait_idle();
    chk("d_div0_LO", LO, 32'hFFFFFFFD);
    chk("d_div0_HI", HI, 32'hFFFFFFFF);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle();
    chk("d_divovf_LO", LO, 32'h80000000);
    chk("d_divovf_HI", HI, 32'd0);
`else
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    issue(4'd0, '0, '0, 1'b0);
    chk("d_nodiv_HI", HI, 32'd1);
    chk("d_nodiv_LO", LO, 32'hFFFFFFFE);
`endif

    // mthi during busy is dropped; after busy falls it takes effect
    issue(4'd1, 32'd2, 32'd3, 1'b1);
    issue(4'd8, 32'h1234, '0, 1'b1);
    wait_idle();
    chk("d_mthi_busy_HI", HI, 32'd0);
    issue(4'd8, 32'h1234, '0, 1'b1);
    @(negedge clk);
    HLOp = 4'd6; en = 1'b1;
    #1;
    chk("d_mfhi", MDOut, 32'h1234);

    // reset on the 3rd busy cycle of a mult, second mult ignored
    issue(4'd1, 32'd100, 32'd100, 1'b1);
    issue(4'd1, 32'd7, 32'd7, 1'b1);
    issue(4'd0, '0, '0, 1'b0);
    @(negedge clk);
    en = 1'b1; HLOp = 4'd1; reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_start", {31'b0, start}, 32'd0);
    chk("mid_rst_HI", HI, 32'd0);
    chk("mid_rst_LO", LO, 32'd0);
    scb.delete();
    arch_hi = '0;
    arch_lo = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    repeat (8) issue(4'd0, '0, '0, 1'b0);
    chk("post_rst_HI", HI, 32'd0);
    chk("post_rst_LO", LO, 32'd0);

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), ($urandom_range(0, 7) != 0));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and HI/LO width in bits (minimum 8).
REQ-002 SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for mult/multu (minimum 1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for div/divu (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: the E-stage instruction is valid and not flushed.
REQ-007 SHALL have port HLOp, input, 4 bits, with fixed encoding: none=0, mult=1, multu=2, div=3, divu=4, mflo=5, mfhi=6, mtlo=7, mthi=8.
REQ-008 SHALL have port A, input, WIDTH bits: the rs operand.
REQ-009 SHALL have port B, input, WIDTH bits: the rt operand.
REQ-010 SHALL have port start, output, 1 bit: a mult/div is accepted this cycle (combinational).
REQ-011 SHALL have port busy, output, 1 bit: an operation is in flight (registered).
REQ-012 SHALL have port HI, output, WIDTH bits: the architectural HI register.
REQ-013 SHALL have port LO, output, WIDTH bits: the architectural LO register.
REQ-014 SHALL have port MDOut, output, WIDTH bits: equal to HI when HLOp=mfhi, otherwise LO (combinational).

Function
REQ-015 SHALL implement the FSM states IDLE and BUSY, plus a down-counter of width clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
REQ-016 SHALL compute start = en & ~busy & (HLOp in 1..4).
REQ-017 SHALL, when start=1, perform IDLE->BUSY, load the counter with MULT_CYCLES or DIV_CYCLES, and capture the computed result into pending registers at that edge.
REQ-018 SHALL compute mult as the signed 2*WIDTH product and multu as the unsigned 2*WIDTH product, with HI receiving the upper WIDTH bits and LO the lower WIDTH bits.
REQ-019 SHALL compute div and divu with LO = quotient truncated toward zero and HI = remainder, where the remainder takes the sign of the dividend for div.
REQ-020 SHALL, for div with A = most-negative value and B = -1, produce LO = A and HI = 0.
REQ-021 SHALL, for div or divu with B = 0, accept the operation and run the normal cycle count, but leave HI and LO unchanged at commit.
REQ-022 SHALL hold busy=1 for exactly N cycles following the start edge, where N is the latency of the accepted operation.
REQ-023 SHALL, on the edge where the counter reaches 0, write the pending results into HI/LO and take BUSY->IDLE; the new HI/LO are visible in the first cycle with busy=0.
REQ-024 SHALL, for mthi/mtlo with en=1 and busy=0, write A into HI or LO respectively at the next edge.
REQ-025 SHALL ignore mthi/mtlo while busy=1 (no write), because the hazard unit stalls them.
REQ-026 SHALL ignore any mult/div HLOp while busy=1 (no restart, no change to in-flight state).
REQ-027 SHALL give mfhi/mflo no side effects; while busy=1, MDOut returns the pre-operation HI/LO.
REQ-028 SHALL treat en=0 and HLOp=none as no-ops in every state.
REQ-029 SHALL treat HLOp values 9..15 as none.

Reset
REQ-030 SHALL, on reset=1 (at any time, including mid-operation), immediately force state=IDLE, counter=0, busy=0, HI=0, LO=0 and pending registers=0, and discard any in-flight result.
REQ-031 SHALL give start and MDOut defined values during reset (0 and LO=0 respectively).

Configuration
REQ-032 SHALL support the macro MDU_DIV_EN: when defined, div/divu behave per REQ-019..REQ-021.
REQ-033 SHALL, when MDU_DIV_EN is undefined, contain no divider logic, decode HLOp=3/4 as none (start=0, busy stays 0, HI/LO unchanged), and leave DIV_CYCLES unused.

Verification
REQ-034 SHALL cover: defaults, mult A=-3, B=7, en=1 -> start=1 for one cycle, busy=1 for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-035 SHALL cover: multu A=32'hFFFFFFFF, B=2 -> HI=1, LO=32'hFFFFFFFE after 5 busy cycles.
REQ-036 SHALL cover: div A=-7, B=2 (MDU_DIV_EN defined) -> busy=1 for 10 cycles, then LO=-3, HI=-1; div A=5, B=0 -> HI/LO retain prior values.
REQ-037 SHALL cover: mthi A=32'h1234 while busy=1 -> HI unchanged; the same op issued after busy falls -> HI=32'h1234; mfhi gives MDOut=32'h1234.
REQ-038 SHALL cover: reset pulsed on the 3rd busy cycle of a mult -> busy=0 and HI=LO=0 immediately, no later commit; a second mult issued during busy is ignored.
REQ-039 SHALL cover: MDU_DIV_EN undefined, HLOp=3 -> start=0, busy=0, HI/LO unchanged.
